// File: rtl/pri_sel.sv
// Registered fixed-priority selector: grants one requester, muxes its payload out and routes the response back.
// Define PRISEL_ROUND_ROBIN_EN to rotate priority after each grant instead of fixing port 0 highest.
module pri_sel #(
   parameter int  NumPorts = 4,
   parameter type T        = logic [0:0],
   parameter type O        = logic [0:0]
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [NumPorts-1:0] inb,
   output logic                valid,
   input  T                    ins  [NumPorts],
   output T                    sel_i,
   input  O                    sel_o,
   output O                    outs [NumPorts]
);

   localparam int IdxW = $clog2(NumPorts);

   logic [IdxW-1:0] winner;
   logic            any;
   logic [IdxW-1:0] idx_q;
   logic            valid_q;

   assign any = |inb;

`ifdef PRISEL_ROUND_ROBIN_EN
   logic [IdxW-1:0] ptr_q;
   logic [IdxW-1:0] ptr_d;

   // Walk from the far end back to ptr_q so the last hit is the first in rotated order.
   always_comb begin
      int j;
      j = 0;
      winner = '0;
      for (int k = NumPorts - 1; k >= 0; k--) begin
         j = (int'(ptr_q) + k) % NumPorts;
         if (inb[j[IdxW-1:0]]) winner = j[IdxW-1:0];
      end
   end

   always_comb begin
      ptr_d = winner + IdxW'(1);
      if (winner == IdxW'(NumPorts - 1)) ptr_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else if (enable && any) begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NumPorts - 1; i >= 0; i--) begin
         if (inb[i]) winner = IdxW'(i);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (enable) begin
         valid_q <= any;
         if (any) idx_q <= winner;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign valid = valid_q;

   always_comb begin
      sel_i = '0;
      if (valid_q) sel_i = ins[idx_q];
   end

   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         outs[i] = '0;
         if (valid_q && idx_q == IdxW'(i)) outs[i] = sel_o;
      end
   end

endmodule

// File: tb/tb_pri_sel.sv
// Self-checking bench for pri_sel: vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_pri_sel;

   typedef struct packed {
      logic       a;
      logic [1:0] b;
   } req_t;
   typedef logic [1:0] rsp_t;

   typedef struct {
      bit         en;
      logic [3:0] inb;
      rsp_t       so;
      bit         ev;
      int         fi;
      int         ri;
   } vec_t;

`ifdef PRISEL_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] inb;
   logic       valid;
   req_t       ins [4];
   req_t       sel_i;
   rsp_t       sel_o;
   rsp_t       outs [4];

   int checks = 0;
   int failures = 0;

   // behavioural model state
   bit m_valid;
   int m_idx;
   int m_ptr;

   pri_sel #(
      .NumPorts(4),
      .T       (req_t),
      .O       (rsp_t)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .inb   (inb),
      .valid (valid),
      .ins   (ins),
      .sel_i (sel_i),
      .sel_o (sel_o),
      .outs  (outs)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
   endtask

   // One enabled edge: first requester in search order wins.
   task automatic model_edge();
      int p;
      if (!enable) begin
         m_valid = 1'b0;
      end else if (inb == 4'b0000) begin
         m_valid = 1'b0;
      end else begin
         p = -1;
         for (int k = 0; k < 4; k++) begin
            int c;
            c = RR ? (m_ptr + k) % 4 : k;
            if (p < 0 && inb[c] === 1'b1) p = c;
         end
         m_valid = 1'b1;
         m_idx   = p;
         if (RR) m_ptr = (p + 1) % 4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_exp(input string name, input bit ev, input int eidx);
      req_t es;
      bit   ok;
      checks++;
      ok = 1'b1;
      es = ev ? ins[eidx] : req_t'(3'b000);
      if (valid !== ev) ok = 1'b0;
      if (sel_i !== es) ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (outs[i] !== ((ev && i == eidx) ? sel_o : rsp_t'(2'b00))) ok = 1'b0;
      end
      if (!ok) begin
         failures++;
         $display("FAIL %s: got valid=%b sel_i=%b outs=%b,%b,%b,%b want valid=%b sel_i=%b port=%0d sel_o=%b",
                  name, valid, sel_i, outs[0], outs[1], outs[2], outs[3],
                  ev, es, eidx, sel_o);
      end
   endtask

   task automatic check_model(input string name);
      check_exp(name, m_valid, m_idx);
   endtask

   task automatic set_ins_default();
      ins[0] = 3'b000;
      ins[1] = 3'b101;
      ins[2] = 3'b010;
      ins[3] = 3'b111;
   endtask

   vec_t tbl [10];

   initial begin
      tbl[0] = '{1'b1, 4'b1001, 2'b10, 1'b1, 0, 0};
      tbl[1] = '{1'b1, 4'b0010, 2'b01, 1'b1, 1, 1};
      tbl[2] = '{1'b0, 4'b0010, 2'b01, 1'b0, 0, 0};
      tbl[3] = '{1'b1, 4'b0010, 2'b01, 1'b1, 1, 1};
      tbl[4] = '{1'b1, 4'b0000, 2'b11, 1'b0, 0, 0};
      tbl[5] = '{1'b1, 4'b1000, 2'b11, 1'b1, 3, 3};
      tbl[6] = '{1'b1, 4'b0110, 2'b10, 1'b1, 1, 1};
      tbl[7] = '{1'b1, 4'b0110, 2'b10, 1'b1, 1, 2};
      tbl[8] = '{1'b0, 4'bxxxx, 2'b01, 1'b0, 0, 0};
      tbl[9] = '{1'b1, 4'b1111, 2'b01, 1'b1, 0, 3};

      rst    = 1'b0;
      enable = 1'b0;
      inb    = 4'b0000;
      sel_o  = 2'b00;
      set_ins_default();
      model_reset();

      // reset holds outputs low with and without clock edges
      #3;
      check_exp("reset_t3", 1'b0, 0);
      #14;
      check_exp("reset_t17", 1'b0, 0);
      #1;
      rst    = 1'b1;
      enable = 1'b1;
      inb    = 4'b1001;
      sel_o  = 2'b10;
      #1;
      check_exp("pre_first_edge", 1'b0, 0);

      foreach (tbl[v]) begin
         enable = tbl[v].en;
         inb    = tbl[v].inb;
         sel_o  = tbl[v].so;
         step();
         check_exp($sformatf("vec%0d", v), tbl[v].ev, RR ? tbl[v].ri : tbl[v].fi);
      end

      // same-cycle propagation of response and payload
      enable = 1'b1;
      inb    = 4'b0010;
      sel_o  = 2'b01;
      step();
      check_exp("grant1", 1'b1, 1);
      sel_o = 2'b11;
      #1;
      check_exp("sel_o_comb", 1'b1, 1);
      ins[1] = 3'b110;
      #1;
      check_exp("ins_comb", 1'b1, 1);
      set_ins_default();

      // reset pulse between edges, then held 1001 traffic
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_exp("async_rst", 1'b0, 0);
      rst = 1'b1;
      inb = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         step();
         check_exp($sformatf("hold1001_%0d", k), 1'b1, (RR && k % 2 == 1) ? 3 : 0);
      end
      step();
      check_exp("hold1001_4", 1'b1, 0);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check_exp("midseq_rst", 1'b0, 0);
      rst = 1'b1;
      step();
      check_exp("after_rst_grant", 1'b1, 0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         enable = ($urandom_range(0, 3) != 0);
         inb    = 4'($urandom_range(0, 15));
         sel_o  = 2'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) ins[i] = 3'($urandom_range(0, 7));
         step();
         check_model($sformatf("rand%0d", n));
         if (n % 5 == 0) begin
            sel_o = ~sel_o;
            ins[m_idx] = ~ins[m_idx];
            #1;
            check_model($sformatf("rand_comb%0d", n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
